block_fetch_manager: RTL

// Parametrised successor to the single-core memory manager. Polls a command word in SDRAM via the

---
 rtl/block_fetch_manager.sv | 272 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/block_fetch_manager.sv
// block_fetch_manager
// Polls a command word in SDRAM through the read master. When the command equals START_MAGIC it
// streams BLOCK_WORDS block words into the hashing cores. It then waits for a solution claim,
// acknowledges the lowest-index claimant and writes that core's nonce to NONCE_ADDR. Finally it
// writes DONE_MAGIC to CMD_ADDR and goes back to polling.
//
// Optional feature macro: NONCE_ID_EN
//   When defined, the winning core index (zero-extended) is also written to NONCE_ADDR+DATAWIDTH/8
//   before the completion word.
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   read_control_*                 read master control (go/base/length/fixed_location/done)
//   read_user_*                    read master FIFO (pop strobe, data, data available)
//   write_control_*                write master control (go/base/length/fixed_location/done)
//   write_user_*                   write master FIFO (push strobe, data, full)
//   core_out, shift_out_enable     block word broadcast to all cores, one-cycle shift strobe
//   start_out                      one-cycle pulse once the whole block has been shifted in
//   core_in, sol_claim             per-core nonce (core i at [i*DW +: DW]) and solution claim
//   sol_response                   one-cycle acknowledge to the winning core
//   busy                           low only while polling the command word
module block_fetch_manager #(
    parameter int ADDRESSWIDTH = 28,
    parameter int DATAWIDTH    = 32,
    parameter int BLOCK_WORDS  = 24,
    parameter int NUM_CORES    = 2,
    parameter logic [ADDRESSWIDTH-1:0] CMD_ADDR    = 28'h8000000,
    parameter logic [ADDRESSWIDTH-1:0] BLOCK_ADDR  = 28'h8000008,
    parameter logic [ADDRESSWIDTH-1:0] NONCE_ADDR  = 28'h8000068,
    parameter logic [DATAWIDTH-1:0]    START_MAGIC = 32'hAAAA0000,
    parameter logic [DATAWIDTH-1:0]    DONE_MAGIC  = 32'h5555FFFF
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic                           read_control_go,
    output logic [ADDRESSWIDTH-1:0]        read_control_read_base,
    output logic [ADDRESSWIDTH-1:0]        read_control_read_length,
    output logic                           read_control_fixed_location,
    input  logic                           read_control_done,
    output logic                           read_user_read_buffer,
    input  logic [DATAWIDTH-1:0]           read_user_buffer_output_data,
    input  logic                           read_user_data_available,
    output logic                           write_control_go,
    output logic [ADDRESSWIDTH-1:0]        write_control_write_base,
    output logic [ADDRESSWIDTH-1:0]        write_control_write_length,
    output logic                           write_control_fixed_location,
    input  logic                           write_control_done,
    output logic                           write_user_write_buffer,
    output logic [DATAWIDTH-1:0]           write_user_buffer_data,
    input  logic                           write_user_buffer_full,
    output logic [DATAWIDTH-1:0]           core_out,
    output logic                           shift_out_enable,
    output logic                           start_out,
    input  logic [NUM_CORES*DATAWIDTH-1:0] core_in,
    input  logic [NUM_CORES-1:0]           sol_claim,
    output logic [NUM_CORES-1:0]           sol_response,
    output logic                           busy
);

    localparam int CW = $clog2(BLOCK_WORDS + 1);
    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [ADDRESSWIDTH-1:0] WORD_BYTES = ADDRESSWIDTH'(DATAWIDTH / 8);

    typedef enum logic [4:0] {
        POLL_REQ, POLL_WAIT, POLL_ACK, POLL_CHK,
        BLK_REQ, BLK_WAIT, BLK_ACK, BLK_SHIFT,
        START, WATCH,
        WR_NONCE, WR_NONCE_WAIT,
`ifdef NONCE_ID_EN
        WR_ID, WR_ID_WAIT,
`endif
        WR_CMD, WR_CMD_WAIT
    } state_t;

    state_t                  state, next_state;
    logic [DATAWIDTH-1:0]    data_q;
    logic [CW-1:0]           word_cnt;
    logic [ADDRESSWIDTH-1:0] read_addr;
    logic [ADDRESSWIDTH-1:0] write_addr;
    logic [IW-1:0]           winner;
    logic [DATAWIDTH-1:0]    nonce;
    logic                    claim_any;
    logic [IW-1:0]           claim_idx;
    logic                    last_word;

    assign read_control_read_base       = read_addr;
    assign read_control_read_length     = WORD_BYTES;
    assign read_control_fixed_location  = 1'b1;
    assign write_control_write_base     = write_addr;
    assign write_control_write_length   = WORD_BYTES;
    assign write_control_fixed_location = 1'b1;
    assign last_word = (word_cnt == CW'(BLOCK_WORDS - 1));

    // Lowest-index claimant wins: scanning from the top down leaves the lowest set bit last.
    always_comb begin
        claim_any = |sol_claim;
        claim_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (sol_claim[i]) claim_idx = IW'(i);
        end
    end

    // Next-state and Moore/Mealy strobes. The state register parks in POLL_REQ while reset is
    // held, so strobes are forced low during reset to keep the masters and cores quiet.
    always_comb begin
        next_state              = state;
        read_control_go         = 1'b0;
        read_user_read_buffer   = 1'b0;
        write_control_go        = 1'b0;
        write_user_write_buffer = 1'b0;
        write_user_buffer_data  = '0;
        core_out                = '0;
        shift_out_enable        = 1'b0;
        start_out               = 1'b0;
        sol_response            = '0;
        busy                    = 1'b1;
        unique case (state)
            POLL_REQ: begin
                busy            = 1'b0;
                read_control_go = 1'b1;
                next_state      = POLL_WAIT;
            end
            POLL_WAIT: begin
                busy = 1'b0;
                if (read_control_done) next_state = POLL_ACK;
            end
            POLL_ACK: begin
                busy = 1'b0;
                if (read_user_data_available) begin
                    read_user_read_buffer = 1'b1;
                    next_state            = POLL_CHK;
                end
            end
            POLL_CHK: begin
                busy       = 1'b0;
                next_state = (data_q == START_MAGIC) ? BLK_REQ : POLL_REQ;
            end
            BLK_REQ: begin
                read_control_go = 1'b1;
                next_state      = BLK_WAIT;
            end
            BLK_WAIT: begin
                if (read_control_done) next_state = BLK_ACK;
            end
            BLK_ACK: begin
                if (read_user_data_available) begin
                    read_user_read_buffer = 1'b1;
                    next_state            = BLK_SHIFT;
                end
            end
            BLK_SHIFT: begin
                core_out         = data_q;
                shift_out_enable = 1'b1;
                next_state       = last_word ? START : BLK_REQ;
            end
            START: begin
                start_out  = 1'b1;
                next_state = WATCH;
            end
            WATCH: begin
                if (claim_any) begin
                    sol_response[claim_idx] = 1'b1;
                    next_state              = WR_NONCE;
                end
            end
            WR_NONCE: begin
                write_user_buffer_data = nonce;
                if (!write_user_buffer_full) begin
                    write_control_go        = 1'b1;
                    write_user_write_buffer = 1'b1;
                    next_state              = WR_NONCE_WAIT;
                end
            end
            WR_NONCE_WAIT: begin
`ifdef NONCE_ID_EN
                if (write_control_done) next_state = WR_ID;
`else
                if (write_control_done) next_state = WR_CMD;
`endif
            end
`ifdef NONCE_ID_EN
            WR_ID: begin
                write_user_buffer_data = DATAWIDTH'(winner);
                if (!write_user_buffer_full) begin
                    write_control_go        = 1'b1;
                    write_user_write_buffer = 1'b1;
                    next_state              = WR_ID_WAIT;
                end
            end
            WR_ID_WAIT: begin
                if (write_control_done) next_state = WR_CMD;
            end
`endif
            WR_CMD: begin
                write_user_buffer_data = DONE_MAGIC;
                if (!write_user_buffer_full) begin
                    write_control_go        = 1'b1;
                    write_user_write_buffer = 1'b1;
                    next_state              = WR_CMD_WAIT;
                end
            end
            WR_CMD_WAIT: begin
                if (write_control_done) next_state = POLL_REQ;
            end
            default: next_state = POLL_REQ;
        endcase
        if (reset) begin
            read_control_go         = 1'b0;
            read_user_read_buffer   = 1'b0;
            write_control_go        = 1'b0;
            write_user_write_buffer = 1'b0;
            write_user_buffer_data  = '0;
            core_out                = '0;
            shift_out_enable        = 1'b0;
            start_out               = 1'b0;
            sol_response            = '0;
            busy                    = 1'b0;
        end
    end

    // State register plus the datapath registers that each state updates. The read base returns
    // to CMD_ADDR as the last block word is shifted, so the next job starts polling correctly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= POLL_REQ;
            data_q     <= '0;
            word_cnt   <= '0;
            read_addr  <= CMD_ADDR;
            write_addr <= NONCE_ADDR;
            winner     <= '0;
            nonce      <= '0;
        end else begin
            state <= next_state;
            case (state)
                POLL_ACK, BLK_ACK: begin
                    if (read_user_data_available) data_q <= read_user_buffer_output_data;
                end
                POLL_CHK: begin
                    if (data_q == START_MAGIC) begin
                        read_addr <= BLOCK_ADDR;
                        word_cnt  <= '0;
                    end
                end
                BLK_SHIFT: begin
                    word_cnt  <= word_cnt + CW'(1);
                    read_addr <= last_word ? CMD_ADDR : read_addr + WORD_BYTES;
                end
                WATCH: begin
                    if (claim_any) begin
                        winner     <= claim_idx;
                        nonce      <= core_in[claim_idx*DATAWIDTH +: DATAWIDTH];
                        write_addr <= NONCE_ADDR;
                    end
                end
                WR_NONCE_WAIT: begin
`ifdef NONCE_ID_EN
                    if (write_control_done) write_addr <= NONCE_ADDR + WORD_BYTES;
`else
                    if (write_control_done) write_addr <= CMD_ADDR;
`endif
                end
`ifdef NONCE_ID_EN
                WR_ID_WAIT: begin
                    if (write_control_done) write_addr <= CMD_ADDR;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
